// File: rtl/ahb3lite_sram_resp_if.sv
// AHB3-Lite responder-side bus bundle.
// One instance per slave; master drives address/control, slave returns response.
interface ahb3lite_sram_resp_if;
    logic        sHSEL;
    logic [31:0] sHADDR;
    logic [31:0] sHWDATA;
    logic        sHWRITE;
    logic [2:0]  sHSIZE;
    logic [2:0]  sHBURST;
    logic [3:0]  sHPROT;
    logic [1:0]  sHTRANS;
    logic        sHREADY;
    logic        sHREADYOUT;
    logic        sHRESP;
    logic [31:0] sHRDATA;

    modport slave (
        input  sHSEL, sHADDR, sHWDATA, sHWRITE, sHSIZE,
        input  sHBURST, sHPROT, sHTRANS, sHREADY,
        output sHREADYOUT, sHRESP, sHRDATA
    );

    modport master (
        output sHSEL, sHADDR, sHWDATA, sHWRITE, sHSIZE,
        output sHBURST, sHPROT, sHTRANS, sHREADY,
        input  sHREADYOUT, sHRESP, sHRDATA
    );
endinterface

// File: rtl/ahb3lite_sram_resp.sv
// AHB3-Lite SRAM responder: word memory, byte-lane writes,
// programmable wait states and two-cycle ERROR responses.
module ahb3lite_sram_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic clk_i,
    input logic rst_n_i,
    ahb3lite_sram_resp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lo_q, lo_d;
    logic [1:0]      size_q, size_d;
    logic            wr_q, wr_d;

    logic [31:0]     mem_q [DEPTH];
    logic            open_slot;
    logic            capture;
    logic            addr_err;
    logic            we;
    logic [3:0]      be;
    logic            unused;

    assign unused = ^{bus.sHBURST, bus.sHPROT};

    assign open_slot = (state_q == S_IDLE) || (state_q == S_DATA) ||
                       (state_q == S_ERR2);
    assign capture = open_slot & bus.sHSEL & bus.sHREADY &
                     bus.sHTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        if (bus.sHADDR[31:2] >= 30'(DEPTH)) addr_err = 1'b1;
        if (bus.sHSIZE > 3'd2) addr_err = 1'b1;
        if (bus.sHSIZE == 3'd1 && bus.sHADDR[0]) addr_err = 1'b1;
        if (bus.sHSIZE == 3'd2 && bus.sHADDR[1:0] != 2'd0) addr_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        size_d  = size_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else cnt_d = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (capture) begin
                    idx_d  = bus.sHADDR[AW+1:2];
                    lo_d   = bus.sHADDR[1:0];
                    size_d = bus.sHSIZE[1:0];
                    wr_d   = bus.sHWRITE;
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lo_q    <= 2'd0;
            size_q  <= 2'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
        end
    end

    // Little-endian lane selection from the captured size/offset
    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            2'd0:    be[lo_q] = 1'b1;
            2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign we = (state_q == S_DATA) && wr_q;

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx_q][8*i +: 8] <= bus.sHWDATA[8*i +: 8];
            end
        end
    end

    assign bus.sHREADYOUT = open_slot;
    assign bus.sHRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.sHRDATA    = (state_q == S_DATA) ? mem_q[idx_q] : 32'd0;
endmodule

// File: tb/tb_ahb3lite_sram_resp.sv
// Bench for ahb3lite_sram_resp: one zero-wait and one 3-wait instance
// driven by a pipelined master and checked against a word-array model.
module tb_ahb3lite_sram_resp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        dsel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb3lite_sram_resp_if bus0 ();
    ahb3lite_sram_resp_if bus1 ();

    assign bus0.sHSEL    = hsel & ~dsel;
    assign bus0.sHADDR   = haddr;
    assign bus0.sHWDATA  = hwdata;
    assign bus0.sHWRITE  = hwrite;
    assign bus0.sHSIZE   = hsize;
    assign bus0.sHBURST  = 3'd0;
    assign bus0.sHPROT   = 4'd0;
    assign bus0.sHTRANS  = htrans;
    assign bus0.sHREADY  = bus0.sHREADYOUT;

    assign bus1.sHSEL    = hsel & dsel;
    assign bus1.sHADDR   = haddr;
    assign bus1.sHWDATA  = hwdata;
    assign bus1.sHWRITE  = hwrite;
    assign bus1.sHSIZE   = hsize;
    assign bus1.sHBURST  = 3'd0;
    assign bus1.sHPROT   = 4'd0;
    assign bus1.sHTRANS  = htrans;
    assign bus1.sHREADY  = bus1.sHREADYOUT;

    ahb3lite_sram_resp #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus0)
    );

    ahb3lite_sram_resp #(.DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus1)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } beat_t;

    beat_t       q[$];
    logic [31:0] mem_m [2][1024];
    bit          known [2][1024];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(beat_t b);
        if ((b.addr >> 2) >= 32'd1024) return 1'b1;
        if (b.size > 3'd2) return 1'b1;
        if (b.size == 3'd1 && b.addr[0]) return 1'b1;
        if (b.size == 3'd2 && b.addr[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic cur_rdy();
        return dsel ? bus1.sHREADYOUT : bus0.sHREADYOUT;
    endfunction

    function automatic logic cur_rsp();
        return dsel ? bus1.sHRESP : bus0.sHRESP;
    endfunction

    function automatic logic [31:0] cur_rd();
        return dsel ? bus1.sHRDATA : bus0.sHRDATA;
    endfunction

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        haddr  = 32'd0;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    task automatic drive_addr(beat_t b);
        hsel   = b.sel;
        htrans = b.trans;
        haddr  = b.addr;
        hwrite = b.wr;
        hsize  = b.size;
    endtask

    task automatic push(logic [31:0] a, logic w, logic [2:0] s,
                        logic [31:0] d);
        beat_t b;
        b.sel = 1'b1;
        b.trans = 2'd2;
        b.addr = a;
        b.wr = w;
        b.size = s;
        b.wdata = d;
        q.push_back(b);
    endtask

    task automatic finish_beat(beat_t b, int cyc, int low, int hi,
                               logic [31:0] rd);
        int d  = int'(dsel);
        int ws = dsel ? 3 : 0;
        int ix = int'(b.addr[11:2]);
        string t = $sformatf("d%0d@%h", d, b.addr);
        if (exp_err(b)) begin
            chk({t, " err_cycles"}, cyc, 2);
            chk({t, " err_low"}, low, 1);
            chk({t, " err_resp"}, hi, 2);
            chk({t, " err_rdata"}, rd, 32'd0);
        end else begin
            chk({t, " ok_cycles"}, cyc, ws + 1);
            chk({t, " ok_low"}, low, ws);
            chk({t, " ok_resp"}, hi, 0);
            if (b.wr) begin
                case (b.size)
                    3'd0: mem_m[d][ix][8*b.addr[1:0] +: 8] =
                          b.wdata[8*b.addr[1:0] +: 8];
                    3'd1: mem_m[d][ix][16*b.addr[1] +: 16] =
                          b.wdata[16*b.addr[1] +: 16];
                    default: begin
                        mem_m[d][ix] = b.wdata;
                        known[d][ix] = 1'b1;
                    end
                endcase
            end else if (known[d][ix]) begin
                chk({t, " rdata"}, rd, mem_m[d][ix]);
            end
        end
    endtask

    task automatic run_queue();
        beat_t ap, dp;
        bit ap_v = 0, dp_v = 0, dp_e = 0;
        int cyc = 0, low = 0, hi = 0;
        logic rdy, rsp;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            ap = q.pop_front();
            ap_v = 1;
            drive_addr(ap);
        end
        while (ap_v || dp_v) begin
            @(negedge clk);
            rdy = cur_rdy();
            rsp = cur_rsp();
            rd  = cur_rd();
            if (dp_v) begin
                cyc++;
                if (!rdy) low++;
                if (rsp) hi++;
                if (dp_e && cyc == 1 && ap_v && $urandom_range(0, 1) == 1) begin
                    ap_v = 0;
                    drive_idle();
                end
                if (cyc > 20) begin
                    chk("data_phase_len", cyc, 20);
                    break;
                end
            end else begin
                chk("idle_rdy", {31'd0, rdy}, 1);
                chk("idle_rsp", {31'd0, rsp}, 0);
                chk("idle_rdata", rd, 32'd0);
            end
            @(posedge clk);
            if (rdy) begin
                if (dp_v) finish_beat(dp, cyc, low, hi, rd);
                dp_v = 0;
                if (ap_v && ap.sel && ap.trans[1]) begin
                    dp = ap;
                    dp_v = 1;
                    dp_e = exp_err(ap);
                    cyc = 0;
                    low = 0;
                    hi = 0;
                end
                ap_v = 0;
                #1;
                if (dp_v) hwdata = dp.wdata;
                if (q.size() > 0) begin
                    ap = q.pop_front();
                    ap_v = 1;
                    drive_addr(ap);
                end else begin
                    drive_idle();
                end
            end else begin
                #1;
            end
        end
        drive_idle();
    endtask

    function automatic logic [31:0] pick_addr();
        int k = $urandom_range(0, 19);
        logic [31:0] a;
        if (k < 16) a = 32'h100 + 32'(k * 4);
        else if (k == 16) a = 32'h0;
        else if (k == 17) a = 32'hFFC;
        else if (k == 18) a = 32'h1000;
        else a = 32'hFFFF_FFF0;
        return a + 32'($urandom_range(0, 3));
    endfunction

    task automatic rand_chunk(int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int r = $urandom_range(0, 9);
            b.sel   = ($urandom_range(0, 9) != 0);
            b.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 :
                      (r < 6) ? 2'd2 : 2'd3;
            b.addr  = pick_addr();
            b.wr    = 1'($urandom_range(0, 1));
            b.size  = ($urandom_range(0, 7) == 0) ?
                      3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (b.size == 3'd2 && $urandom_range(0, 3) != 0)
                b.addr[1:0] = 2'd0;
            if (b.size == 3'd1 && $urandom_range(0, 3) != 0)
                b.addr[0] = 1'b0;
            b.wdata = $urandom;
            q.push_back(b);
        end
        run_queue();
    endtask

    initial begin
        rst_n  = 1'b0;
        dsel   = 1'b0;
        hwdata = 32'd0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy0", {31'd0, bus0.sHREADYOUT}, 1);
        chk("rst_rsp0", {31'd0, bus0.sHRESP}, 0);
        chk("rst_rd0", bus0.sHRDATA, 32'd0);
        chk("rst_rdy1", {31'd0, bus1.sHREADYOUT}, 1);
        chk("rst_rsp1", {31'd0, bus1.sHRESP}, 0);
        chk("rst_rd1", bus1.sHRDATA, 32'd0);
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            dsel = 1'(d);
            for (int k = 0; k < 16; k++)
                push(32'h100 + 32'(k * 4), 1'b1, 3'd2, $urandom);
            push(32'h0, 1'b1, 3'd2, 32'hC0DE_0000);
            push(32'hFFC, 1'b1, 3'd2, $urandom);
            push(32'h40, 1'b1, 3'd2, 32'h0BAD_F00D);
            run_queue();
        end

        dsel = 1'b0;
        push(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
        push(32'h10, 1'b0, 3'd2, 32'd0);
        push(32'h20, 1'b1, 3'd2, 32'h1122_3344);
        push(32'h21, 1'b1, 3'd0, {4{8'hAA}});
        push(32'h20, 1'b0, 3'd2, 32'd0);
        push(32'h22, 1'b1, 3'd1, {2{16'hBEEF}});
        push(32'h20, 1'b0, 3'd2, 32'd0);
        push(32'h1000, 1'b1, 3'd2, 32'hFFFF_FFFF);
        push(32'h0, 1'b0, 3'd2, 32'd0);
        push(32'h2, 1'b0, 3'd2, 32'd0);
        push(32'h3, 1'b0, 3'd1, 32'd0);
        push(32'h2, 1'b0, 3'd1, 32'd0);
        run_queue();

        dsel = 1'b1;
        push(32'h100, 1'b0, 3'd2, 32'd0);
        push(32'h104, 1'b0, 3'd2, 32'd0);
        push(32'h1000, 1'b1, 3'd2, 32'h1234_5678);
        push(32'h0, 1'b0, 3'd2, 32'd0);
        run_queue();

        @(posedge clk);
        #1;
        hsel = 1'b1;
        htrans = 2'd2;
        haddr = 32'h40;
        hwrite = 1'b1;
        hsize = 3'd2;
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("wait_rdy", {31'd0, bus1.sHREADYOUT}, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rdy", {31'd0, bus1.sHREADYOUT}, 1);
        chk("arst_rsp", {31'd0, bus1.sHRESP}, 0);
        chk("arst_rd", bus1.sHRDATA, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        push(32'h40, 1'b0, 3'd2, 32'd0);
        run_queue();

        for (int c = 0; c < 8; c++) begin
            dsel = 1'(c % 2);
            rand_chunk(50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
